// File: rtl/key_press_pkg.sv
// Shared constants and width helpers for the key press array.
package key_press_pkg;

  localparam int unsigned NUM_KEYS_DEF        = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned REPEAT_DELAY_DEF    = 8;
  localparam int unsigned REPEAT_PERIOD_DEF   = 3;
  localparam int unsigned SYNC_STAGES         = 2;

  // Bits needed to hold values 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchroniser, stable-count debounce, press/release pulses.
// Auto-repeat hold counter present only when KEY_PRESS_REPEAT_EN is defined.
module key_debounce_channel
  import key_press_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_PRESS_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_key,
  output logic o_press,
  output logic o_release,
  output logic o_level,
  output logic o_press_c
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   w_commit;
  logic                   w_press_nxt;
  logic                   w_release_nxt;

  // Raw key is active-low; the synchroniser carries the pressed sense.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ~i_key};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Any sample agreeing with the stable level discards accumulated credit.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_commit     = 1'b0;
    if (w_synced == r_stable) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_commit     = 1'b1;
      w_stable_nxt = w_synced;
      w_cnt_nxt    = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign w_release_nxt = w_commit & ~w_synced;

`ifdef KEY_PRESS_REPEAT_EN
  localparam int unsigned HOLD_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HOLD_W-1:0] HOLD_DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_rep;
  logic              w_rep_nxt;
  logic              w_rep_fire;

  // A commit in either direction restarts the hold timer and blocks a repeat that edge.
  always_comb begin
    w_hold_nxt = r_hold;
    w_rep_nxt  = r_rep;
    w_rep_fire = 1'b0;
    if (w_commit) begin
      w_hold_nxt = '0;
      w_rep_nxt  = 1'b0;
    end else if (r_stable) begin
      if (r_hold == (r_rep ? HOLD_PERIOD_LAST : HOLD_DELAY_LAST)) begin
        w_rep_fire = 1'b1;
        w_hold_nxt = '0;
        w_rep_nxt  = 1'b1;
      end else begin
        w_hold_nxt = r_hold + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_rep  <= w_rep_nxt;
    end
  end

  assign w_press_nxt = (w_commit & w_synced) | w_rep_fire;
`else
  assign w_press_nxt = w_commit & w_synced;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_stable  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
    end
  end

  assign o_level   = r_stable;
  assign o_press_c = w_press_nxt;

endmodule

// File: rtl/key_press_array.sv
// NUM_KEYS independent debounced key channels plus a registered any-press pulse.
// Define KEY_PRESS_REPEAT_EN to enable per-key auto-repeat press pulses.
module key_press_array
  import key_press_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = NUM_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                key_press_any
);

  logic [NUM_KEYS-1:0] w_press_c;
  logic                r_press_any;

  // Zero-valued parameters are not a legal configuration; this marker block flags one.
  if (NUM_KEYS == 0 || DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)
  begin : g_illegal_cfg
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_PRESS_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_key     (key[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_level   (key_level[g]),
      .o_press_c (w_press_c[g])
    );
  end

  // Registered from the channels' next-pulse terms so it aligns with key_press.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_press_any <= 1'b0;
    end else begin
      r_press_any <= |w_press_c;
    end
  end

  assign key_press_any = r_press_any;

endmodule

// File: tb/tb_key_press_array.sv
// Directed and randomized checks of key_press_array against a behavioural model.
module tb_key_press_array;

  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 8;
  localparam int unsigned RP  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_level;
  logic          key_press_any;

  int n_cmp = 0;
  int n_err = 0;

  key_press_array #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key           (key),
    .key_press     (key_press),
    .key_release   (key_release),
    .key_level     (key_level),
    .key_press_any (key_press_any)
  );

  always #5 clock = ~clock;

  // Behavioural model: pressed sense reaches the filter two edges late; a level is
  // accepted after DEB consecutive disagreeing samples; repeats follow commit age.
  logic [NK-1:0]  m_s1 = '0;
  logic [NK-1:0]  m_s2 = '0;
  logic [NK-1:0]  m_stable = '0;
  int unsigned    m_run [NK] = '{default: 0};
  int unsigned    m_age [NK] = '{default: 0};
  logic [NK-1:0]  exp_press = '0;
  logic [NK-1:0]  exp_rel = '0;
  logic           exp_any = 1'b0;

  always @(posedge clock) begin : model
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    p = '0;
    r = '0;
    if (!reset_n) begin
      m_s1 = '0;
      m_s2 = '0;
      m_stable = '0;
      for (int i = 0; i < NK; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
    end else begin
      for (int i = 0; i < NK; i++) begin
        if (m_stable[i]) m_age[i]++;
        if (m_s2[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          m_stable[i] = m_s2[i];
          if (m_s2[i]) begin
            p[i] = 1'b1;
            m_age[i] = 0;
          end else begin
            r[i] = 1'b1;
          end
        end
`ifdef KEY_PRESS_REPEAT_EN
        else if (m_stable[i] && m_age[i] >= RD && (m_age[i] - RD) % RP == 0) begin
          p[i] = 1'b1;
        end
`endif
      end
      m_s2 = m_s1;
      m_s1 = ~key;
    end
    exp_press = p;
    exp_rel   = r;
    exp_any   = |p;
  end

  wire [3*NK:0] w_obs = {key_press, key_release, key_level, key_press_any};
  wire [3*NK:0] w_exp = {exp_press, exp_rel, m_stable, exp_any};

  task automatic test_reset;
    reset_n = 1'b0;
    key     = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== '0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d obs=%h exp=0", k, w_obs);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL reset_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press !== ((k == 5) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("FAIL reset_held_press k=%0d press=%b", k, key_press);
      end
    end
    key = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL reset_settle k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_clean_press;
    key[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      n_cmp += 4;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL press_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press[0] !== (k == 5)) begin
        n_err++;
        $display("FAIL press_pulse k=%0d got=%b", k, key_press[0]);
      end
      if (key_level[0] !== (k >= 5)) begin
        n_err++;
        $display("FAIL press_level k=%0d got=%b", k, key_level[0]);
      end
      if (key_press_any !== (k == 5)) begin
        n_err++;
        $display("FAIL press_any k=%0d got=%b", k, key_press_any);
      end
    end
  endtask

  task automatic test_release;
    key[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp += 4;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL release_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_release[0] !== (k == 5)) begin
        n_err++;
        $display("FAIL release_pulse k=%0d got=%b", k, key_release[0]);
      end
      if (key_level[0] !== (k < 5)) begin
        n_err++;
        $display("FAIL release_level k=%0d got=%b", k, key_level[0]);
      end
      if (key_press !== 4'h0) begin
        n_err++;
        $display("FAIL release_nopress k=%0d press=%b", k, key_press);
      end
    end
  endtask

  task automatic test_bounce;
    int k;
    logic [7:0] pattern;
    pattern = 8'b1111_1000;
    for (int b = 0; b < 4; b++) begin
      key[1] = (b == 3);
      @(negedge clock);
      n_cmp++;
      if (key_press[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bounce_early b=%0d got=%b", b, key_press[1]);
      end
    end
    key[1] = 1'b0;
    for (k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL bounce_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press[1] !== (k == 5)) begin
        n_err++;
        $display("FAIL bounce_pulse k=%0d got=%b", k, key_press[1]);
      end
    end
    key[1] = pattern[0] | 1'b1;
    for (k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL bounce_settle k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_simultaneous;
    key[3:2] = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp += 3;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL simul_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press !== ((k == 5) ? 4'b1100 : 4'b0000)) begin
        n_err++;
        $display("FAIL simul_press k=%0d press=%b", k, key_press);
      end
      if (key_press_any !== (k == 5)) begin
        n_err++;
        $display("FAIL simul_any k=%0d got=%b", k, key_press_any);
      end
    end
    key = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL simul_settle k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_mid_reset;
    key[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_cmp++;
      if (key_press[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_pre k=%0d got=%b", k, key_press[0]);
      end
    end
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== '0) begin
        n_err++;
        $display("FAIL midrst_hold k=%0d obs=%h exp=0", k, w_obs);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL midrst_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press[0] !== (k == 5)) begin
        n_err++;
        $display("FAIL midrst_pulse k=%0d got=%b", k, key_press[0]);
      end
    end
    key = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL midrst_settle k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_repeat;
    logic want;
    key[0] = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clock);
`ifdef KEY_PRESS_REPEAT_EN
      want = (k == 5) || (k >= 5 + int'(RD) && (k - 5 - int'(RD)) % int'(RP) == 0);
`else
      want = (k == 5);
`endif
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL repeat_model k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
      if (key_press[0] !== want) begin
        n_err++;
        $display("FAIL repeat_pulse k=%0d got=%b want=%b", k, key_press[0], want);
      end
    end
    key[0] = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clock);
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL repeat_rel_model j=%0d obs=%h exp=%h", j, w_obs, w_exp);
      end
      if (key_release[0] !== (j == 5)) begin
        n_err++;
        $display("FAIL repeat_rel_pulse j=%0d got=%b", j, key_release[0]);
      end
      if (j >= 5) begin
        n_cmp++;
        if (key_press[0] !== 1'b0) begin
          n_err++;
          $display("FAIL repeat_after_rel j=%0d got=%b", j, key_press[0]);
        end
      end
    end
  endtask

  task automatic test_random;
    int hold [NK];
    int rst_left;
    rst_left = 0;
    for (int i = 0; i < NK; i++) hold[i] = int'($urandom_range(1, 20));
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      n_cmp += 2;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL random_model c=%0d obs=%h exp=%h", c, w_obs, w_exp);
      end
      if ((key_press & key_release) !== '0) begin
        n_err++;
        $display("FAIL random_exclusive c=%0d press=%b rel=%b", c, key_press, key_release);
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 199) == 0) rst_left = int'($urandom_range(1, 3));
      reset_n = (rst_left == 0);
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key[i]  = ~key[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 24));
        end else begin
          hold[i]--;
        end
      end
    end
    reset_n = 1'b1;
    key = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (w_obs !== w_exp) begin
        n_err++;
        $display("FAIL random_settle k=%0d obs=%h exp=%h", k, w_obs, w_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
